// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared scancode constants, byte-FSM state type, history
//               entry layout and set-2 scancode to ASCII lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        BASE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
        logic [7:0] ascii;
    } hist_entry_t;

    // Extended keys never carry printable characters; letters are looked up
    // in lower case and folded to upper case when shift is held.
    function automatic logic [7:0] scan_to_ascii(input logic       ext,
                                                 input logic [7:0] code,
                                                 input logic       shift);
        logic [7:0] result;
        result = 8'h00;
        if (!ext) begin
            case (code)
                8'h16: result = "1";
                8'h1E: result = "2";
                8'h26: result = "3";
                8'h25: result = "4";
                8'h2E: result = "5";
                8'h36: result = "6";
                8'h3D: result = "7";
                8'h3E: result = "8";
                8'h46: result = "9";
                8'h45: result = "0";
                8'h29: result = 8'h20;
                8'h1C: result = "a";
                8'h32: result = "b";
                8'h21: result = "c";
                8'h23: result = "d";
                8'h24: result = "e";
                8'h2B: result = "f";
                8'h34: result = "g";
                8'h33: result = "h";
                8'h43: result = "i";
                8'h3B: result = "j";
                8'h42: result = "k";
                8'h4B: result = "l";
                8'h3A: result = "m";
                8'h31: result = "n";
                8'h44: result = "o";
                8'h4D: result = "p";
                8'h15: result = "q";
                8'h2D: result = "r";
                8'h1B: result = "s";
                8'h2C: result = "t";
                8'h3C: result = "u";
                8'h2A: result = "v";
                8'h1D: result = "w";
                8'h22: result = "x";
                8'h35: result = "y";
                8'h1A: result = "z";
                default: result = 8'h00;
            endcase
            if (shift && (result >= 8'h61) && (result <= 8'h7A)) begin
                result = result - 8'h20;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_hist_fifo.sv
`default_nettype none
// ============================================================================
// Module      : key_hist_fifo
// Description : Synchronous first-word-fall-through FIFO holding the history
//               of new key presses. Drops pushes when full (unless a pop
//               frees a slot in the same cycle) and flags a sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module key_hist_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_level = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_overflow;

    logic [AW:0]      w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    // Extra pointer bit keeps full (level == DEPTH) distinct from empty.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (w_level == '0);
    assign w_full    = (w_level == c_full_level);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Storage write; contents need no reset since the head is gated by level.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    // Pointer and sticky overflow bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_valid    = !w_empty;
    assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_level    = w_level;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : PS/2 set-2 scancode decoder. Tracks make/break/E0 sequences,
//               shift state, filters typematic repeats, counts new presses
//               and logs each new press into a pop-able history FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int HIST_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  ps2_data,
    input  logic                        ps2_valid,
    output logic                        key_active,
    output logic [7:0]                  key_code,
    output logic                        key_ext,
    output logic [7:0]                  key_ascii,
    output logic                        shift_held,
    output logic [CNT_W-1:0]            press_cnt,
    output logic                        hist_valid,
    output logic [7:0]                  hist_code,
    output logic                        hist_ext,
    output logic [7:0]                  hist_ascii,
    input  logic                        hist_pop,
    output logic [$clog2(HIST_DEPTH):0] hist_level,
    output logic                        overflow
);

    ps2_state_t       r_state;
    logic             r_shift_l;
    logic             r_shift_r;
    logic             r_key_active;
    logic [7:0]       r_key_code;
    logic             r_key_ext;
    logic [7:0]       r_key_ascii;
    logic [CNT_W-1:0] r_press_cnt;

    logic             w_is_make;
    logic             w_is_break;
    logic             w_ev_ext;
    logic             w_is_shift;
    logic             w_same_key;
    logic             w_new_make;
    logic             w_key_release;
    logic [7:0]       w_ascii;
    hist_entry_t      w_push_entry;
    hist_entry_t      w_head_entry;

    // Classify the incoming byte as a make or break event given the prefix state.
    always_comb begin
        w_is_make  = 1'b0;
        w_is_break = 1'b0;
        w_ev_ext   = 1'b0;
        if (ps2_valid) begin
            case (r_state)
                BASE: begin
                    w_is_make = (ps2_data != SC_EXT) && (ps2_data != SC_BRK);
                end
                EXT: begin
                    w_is_make = (ps2_data != SC_EXT) && (ps2_data != SC_BRK);
                    w_ev_ext  = 1'b1;
                end
                BRK: begin
                    w_is_break = 1'b1;
                end
                EXT_BRK: begin
                    w_is_break = 1'b1;
                    w_ev_ext   = 1'b1;
                end
                default: begin
                    w_is_make = 1'b0;
                end
            endcase
        end
    end

    assign w_is_shift    = !w_ev_ext && ((ps2_data == SC_LSHIFT) || (ps2_data == SC_RSHIFT));
    assign w_same_key    = ({w_ev_ext, ps2_data} == {r_key_ext, r_key_code});
    assign w_new_make    = w_is_make && !w_is_shift && !(r_key_active && w_same_key);
    assign w_key_release = w_is_break && !w_is_shift && w_same_key;
    // Case selection uses the shift state in effect before this byte.
    assign w_ascii       = scan_to_ascii(w_ev_ext, ps2_data, r_shift_l | r_shift_r);

    // Prefix-tracking byte FSM; advances once per strobed byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BASE;
        end else if (ps2_valid) begin
            case (r_state)
                BASE: begin
                    if (ps2_data == SC_EXT) begin
                        r_state <= EXT;
                    end else if (ps2_data == SC_BRK) begin
                        r_state <= BRK;
                    end
                end
                EXT: begin
                    if (ps2_data == SC_BRK) begin
                        r_state <= EXT_BRK;
                    end else if (ps2_data != SC_EXT) begin
                        r_state <= BASE;
                    end
                end
                BRK:     r_state <= BASE;
                EXT_BRK: r_state <= BASE;
                default: r_state <= BASE;
            endcase
        end
    end

    // Left/right shift flags follow their make and break events.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_l <= 1'b0;
            r_shift_r <= 1'b0;
        end else if ((w_is_make || w_is_break) && w_is_shift) begin
            if (ps2_data == SC_LSHIFT) begin
                r_shift_l <= w_is_make;
            end else begin
                r_shift_r <= w_is_make;
            end
        end
    end

    // Current-key register and press counter; repeats leave both untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_active <= 1'b0;
            r_key_code   <= 8'h00;
            r_key_ext    <= 1'b0;
            r_key_ascii  <= 8'h00;
            r_press_cnt  <= '0;
        end else if (w_new_make) begin
            r_key_active <= 1'b1;
            r_key_code   <= ps2_data;
            r_key_ext    <= w_ev_ext;
            r_key_ascii  <= w_ascii;
            r_press_cnt  <= r_press_cnt + CNT_W'(1);
        end else if (w_key_release) begin
            r_key_active <= 1'b0;
        end
    end

    assign w_push_entry.ext   = w_ev_ext;
    assign w_push_entry.code  = ps2_data;
    assign w_push_entry.ascii = w_ascii;

    key_hist_fifo #(
        .DEPTH (HIST_DEPTH),
        .WIDTH ($bits(hist_entry_t))
    ) u_hist (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_new_make),
        .i_push_data (w_push_entry),
        .i_pop       (hist_pop),
        .o_valid     (hist_valid),
        .o_head      (w_head_entry),
        .o_level     (hist_level),
        .o_overflow  (overflow)
    );

    assign key_active = r_key_active;
    assign key_code   = r_key_code;
    assign key_ext    = r_key_ext;
    assign key_ascii  = r_key_ascii;
    assign shift_held = r_shift_l | r_shift_r;
    assign press_cnt  = r_press_cnt;
    assign hist_code  = w_head_entry.code;
    assign hist_ext   = w_head_entry.ext;
    assign hist_ascii = w_head_entry.ascii;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Scoreboard bench for ps2_key_decoder. A driver applies byte /
//               pop events and queues the reference model's expected state;
//               a monitor compares the DUT one half-cycle after each event.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    localparam int CNT_W      = 8;
    localparam int HIST_DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] ps2_data;
    logic       ps2_valid;
    logic       hist_pop;
    logic       key_active;
    logic [7:0] key_code;
    logic       key_ext;
    logic [7:0] key_ascii;
    logic       shift_held;
    logic [7:0] press_cnt;
    logic       hist_valid;
    logic [7:0] hist_code;
    logic       hist_ext;
    logic [7:0] hist_ascii;
    logic [2:0] hist_level;
    logic       overflow;

    ps2_key_decoder #(.CNT_W(CNT_W), .HIST_DEPTH(HIST_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_data   (ps2_data),
        .ps2_valid  (ps2_valid),
        .key_active (key_active),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_ascii  (key_ascii),
        .shift_held (shift_held),
        .press_cnt  (press_cnt),
        .hist_valid (hist_valid),
        .hist_code  (hist_code),
        .hist_ext   (hist_ext),
        .hist_ascii (hist_ascii),
        .hist_pop   (hist_pop),
        .hist_level (hist_level),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tables: set-2 codes for 'a'..'z' and for '1'..'9','0'
    bit [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    bit [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                   8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};

    typedef struct {
        bit       ext;
        bit [7:0] code;
        bit [7:0] ascii;
    } entry_t;

    typedef struct {
        bit       active;
        bit [7:0] code;
        bit       ext;
        bit [7:0] ascii;
        bit       shift;
        bit [7:0] cnt;
        int       level;
        bit       hvalid;
        bit [7:0] hcode;
        bit       hext;
        bit [7:0] hascii;
        bit       ovf;
    } snap_t;

    snap_t  exp_q [$];
    entry_t m_fifo [$];

    // Reference model state
    bit       m_pend_ext, m_pend_brk, m_shl, m_shr;
    bit       m_active, m_ext, m_ovf;
    bit [7:0] m_code, m_ascii;
    int       m_cnt;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [7:0] ref_ascii(input bit ext, input bit [7:0] c, input bit sh);
        if (ext) return 8'h00;
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c) return (sh ? 8'h41 : 8'h61) + 8'(i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c) return (i == 9) ? 8'h30 : 8'h31 + 8'(i);
        if (c == 8'h29) return 8'h20;
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_pend_ext = 0; m_pend_brk = 0; m_shl = 0; m_shr = 0;
        m_active = 0; m_ext = 0; m_ovf = 0; m_code = 0; m_ascii = 0; m_cnt = 0;
        m_fifo.delete();
    endtask

    // One complete key event (after any prefixes); reports whether to log it.
    task automatic model_key(input bit ext, input bit brk, input bit [7:0] c,
                             output bit push, output entry_t e);
        bit same;
        push = 0;
        e = '{ext: ext, code: c, ascii: 8'h00};
        same = m_active && (m_ext == ext) && (m_code == c);
        if (!ext && (c == 8'h12 || c == 8'h59)) begin
            if (c == 8'h12) m_shl = !brk; else m_shr = !brk;
        end else if (brk) begin
            if (same) m_active = 0;
        end else if (!same) begin
            e.ascii  = ref_ascii(ext, c, m_shl || m_shr);
            m_active = 1; m_ext = ext; m_code = c; m_ascii = e.ascii;
            m_cnt    = (m_cnt + 1) % 256;
            push     = 1;
        end
    endtask

    task automatic model_step(input bit v, input bit [7:0] d, input bit p);
        bit     push;
        entry_t e;
        push = 0;
        if (v) begin
            if (!m_pend_brk && d == 8'hE0) m_pend_ext = 1;
            else if (!m_pend_brk && d == 8'hF0) m_pend_brk = 1;
            else begin
                model_key(m_pend_ext, m_pend_brk, d, push, e);
                m_pend_ext = 0; m_pend_brk = 0;
            end
        end
        if (p && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (push) begin
            if (m_fifo.size() < HIST_DEPTH) m_fifo.push_back(e);
            else m_ovf = 1;
        end
    endtask

    function automatic snap_t snap();
        snap_t s;
        s.active = m_active; s.code = m_code; s.ext = m_ext; s.ascii = m_ascii;
        s.shift = m_shl || m_shr; s.cnt = 8'(m_cnt); s.level = m_fifo.size();
        s.hvalid = (m_fifo.size() > 0); s.ovf = m_ovf;
        if (m_fifo.size() > 0) begin
            s.hcode = m_fifo[0].code; s.hext = m_fifo[0].ext; s.hascii = m_fifo[0].ascii;
        end else begin
            s.hcode = 0; s.hext = 0; s.hascii = 0;
        end
        return s;
    endfunction

    // Driver: apply one event for one cycle and queue the expected result
    task automatic step(input bit v, input bit [7:0] d, input bit p);
        ps2_valid = v; ps2_data = d; hist_pop = p;
        if (v || p) begin
            model_step(v, d, p);
            exp_q.push_back(snap());
        end
        @(negedge clk);
        ps2_valid = 0; ps2_data = 0; hist_pop = 0;
    endtask

    task automatic send(input bit [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    // Monitor: compare full DUT state half a cycle after every applied event
    initial begin
        snap_t s;
        forever begin
            @(posedge clk);
            if (!rst && (ps2_valid || hist_pop)) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL scoreboard_empty: DUT event with no expectation at %0t", $time);
                end else begin
                    s = exp_q.pop_front();
                    check("key_active", key_active, s.active);
                    check("key_code",   key_code,   s.code);
                    check("key_ext",    key_ext,    s.ext);
                    check("key_ascii",  key_ascii,  s.ascii);
                    check("shift_held", shift_held, s.shift);
                    check("press_cnt",  press_cnt,  s.cnt);
                    check("hist_level", hist_level, s.level);
                    check("hist_valid", hist_valid, s.hvalid);
                    check("hist_code",  hist_code,  s.hcode);
                    check("hist_ext",   hist_ext,   s.hext);
                    check("hist_ascii", hist_ascii, s.hascii);
                    check("overflow",   overflow,   s.ovf);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [7:0] c;
        int       r;
        rst = 1; ps2_data = 0; ps2_valid = 0; hist_pop = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        // Reset state
        check("rst_key_active", key_active, 0);
        check("rst_key_code",   key_code,   0);
        check("rst_key_ext",    key_ext,    0);
        check("rst_key_ascii",  key_ascii,  0);
        check("rst_shift_held", shift_held, 0);
        check("rst_press_cnt",  press_cnt,  0);
        check("rst_hist_valid", hist_valid, 0);
        check("rst_hist_level", hist_level, 0);
        check("rst_hist_head",  {hist_ext, hist_code, hist_ascii}, 0);
        check("rst_overflow",   overflow,   0);

        // Repeat filtering then break
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        pop_one();
        // Shifted letter
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        pop_one();
        // Extended key make/break
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        pop_one();
        // Fill past depth without popping, then drain
        for (int i = 0; i < 5; i++) begin
            send(letter_codes[i]); send(8'hF0); send(letter_codes[i]);
        end
        repeat (5) pop_one();

        // Push/pop in the same cycle while full
        for (int i = 0; i < 4; i++) send(digit_codes[i]);
        step(1'b1, 8'h29, 1'b1);
        repeat (4) pop_one();

        // Counter wrap over 256 distinct presses
        do_reset();
        for (int i = 0; i < 257; i++) begin
            c = letter_codes[i % 26];
            step(1'b1, c, 1'b1);
            send(8'hF0); send(c);
        end

        // Reset in the middle of an E0 sequence
        send(8'hE0);
        do_reset();
        send(8'h75);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       c = 8'hE0;
            else if (r < 20) c = 8'hF0;
            else if (r < 28) c = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
            else if (r < 58) c = letter_codes[$urandom_range(0, 25)];
            else if (r < 70) c = digit_codes[$urandom_range(0, 9)];
            else if (r < 74) c = 8'h29;
            else             c = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            if (r == 0)      step(1'b0, 8'h00, 1'b0);
            else if (r == 1) pop_one();
            else             step(1'b1, c, ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 scancode decoder between the PS/2 byte receiver and the seven-segment/display logic. Tracks make, break and E0-extended sequences, and keeps left/right shift state so letter keys decode to upper or lower case. Suppresses typematic repeats and counts distinct key presses. Buffers every new key press in a pop-able history FIFO so software or display logic can consume keys at its own rate.

## Interface
- `CNT_W`, default 8: width of the key-press counter.
- `HIST_DEPTH`, default 4: history FIFO entries. Must be a power of 2 and at least 2.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `ps2_data` input, 8 bits: received scancode byte. Valid only when `ps2_valid` is 1.
- `ps2_valid` input, 1 bit: one-cycle strobe, one per received byte.
- `key_active` output, 1 bit: a non-shift key is currently held.
- `key_code` output, 8 bits: scancode of the last new non-shift make.
- `key_ext` output, 1 bit: that key was E0-prefixed.
- `key_ascii` output, 8 bits: ASCII of that key; 0x00 if unmapped.
- `shift_held` output, 1 bit: left or right shift is held.
- `press_cnt` output, `CNT_W` bits: count of new non-shift makes.
- `hist_valid` output, 1 bit: the FIFO is non-empty.
- `hist_code` output, 8 bits: scancode of the head entry.
- `hist_ext` output, 1 bit: E0 flag of the head entry.
- `hist_ascii` output, 8 bits: ASCII of the head entry.
- `hist_pop` input, 1 bit: discard the head entry. Honoured only when `hist_valid` is 1.
- `hist_level` output, clog2(`HIST_DEPTH`)+1 bits: number of entries held.
- `overflow` output, 1 bit: sticky; set when a push is dropped. Cleared only by `rst`.

## Operation
- The byte FSM has four states. Reset state is BASE.
- BASE:
  - 0xE0 goes to EXT.
  - 0xF0 goes to BRK.
  - Any other byte is a make with ext=0 and stays in BASE.
- EXT:
  - 0xF0 goes to EXT_BRK.
  - 0xE0 stays in EXT.
  - Any other byte is a make with ext=1 and goes to BASE.
- BRK: any byte is a break with ext=0 and goes to BASE.
- EXT_BRK: any byte is a break with ext=1 and goes to BASE.
- Shift keys are 0x12 and 0x59, with ext=0.
  - A make sets the matching `shift_l`/`shift_r` flag. A break clears it.
  - `shift_held` = `shift_l` | `shift_r`.
  - Shift events never touch the key, counter or FIFO state.
- Repeat: a make whose {ext, code} equals {`key_ext`, `key_code`} while `key_active`=1 is ignored.
- New make (any other non-shift make), all in the same cycle:
  - `key_code`, `key_ext` and `key_ascii` are loaded, and `key_active` is set to 1.
  - `press_cnt` increments, wrapping modulo 2^`CNT_W`.
  - {ext, code, ascii} is pushed to the FIFO.
- Break matching {`key_ext`, `key_code`} clears `key_active`. Breaks of any other non-shift key are ignored.
- ASCII mapping uses the `shift_held` value from before the current byte. Any ext=1 key gives 0x00.
  - Digits: 0x16,1E,26,25,2E,36,3D,3E,46,45 map to '1'..'9','0', regardless of shift.
  - Letters: standard set-2 codes map to 0x61–0x7A, or to 0x41–0x5A when shift is held. Examples: 0x1C→'a', 0x32→'b', 0x1A→'z'.
  - 0x29 (space) maps to 0x20.
  - Everything else maps to 0x00.
- FIFO rules:
  - Push when full with no pop: the new entry is dropped, `overflow` is set, and contents are unchanged.
  - Push and pop in the same cycle when full: both happen and the level is unchanged.
  - Pop when empty: ignored.
  - Head outputs are 0 when empty.
- Reset values: all outputs are 0 and the FSM returns to BASE.
  - Reset mid-sequence (e.g. after 0xE0) discards the partial sequence.
  - Reset also discards all FIFO contents.

## Timing
- All outputs are registered.
- A byte strobed in cycle N updates `key_*`, `shift_held` and `press_cnt` at cycle N+1.
- A push in cycle N makes `hist_valid` 1 and `hist_level` incremented at N+1. The head is readable at N+1.
- A `hist_pop` in cycle N advances the head at N+1.
- Back-to-back `ps2_valid` strobes on consecutive cycles are supported. Each byte advances the FSM exactly once.
- Cycles without `ps2_valid` change no decode state.

## Structure
- Package `ps2_pkg`:
  - scancode constants `SC_EXT`=0xE0, `SC_BRK`=0xF0, `SC_LSHIFT`=0x12, `SC_RSHIFT`=0x59;
  - the FSM state enum {BASE, EXT, BRK, EXT_BRK};
  - the history entry struct {ext, code[7:0], ascii[7:0]};
  - the ASCII lookup function.
- Sub-module `key_hist_fifo`: a synchronous FIFO with `HIST_DEPTH` entries of 17-bit width.
  - Pointers are clog2(`HIST_DEPTH`)+1 bits wide to distinguish full from empty.
  - Head data is shown in first-word-fall-through style.
- Top level: the FSM, shift flags, repeat filter, counter and ASCII mapping.

## Test plan
- Bytes 1C, 1C, 1C, F0, 1C:
  - `key_active`=1 after the first byte; `key_ascii`=0x61;
  - `press_cnt`=1 after the repeats, with one FIFO entry;
  - `key_active`=0 after the break.
- Bytes 12, 1C, F0, 1C, F0, 12:
  - `shift_held`=1 then 0;
  - `key_ascii`=0x41, and the FIFO head ascii=0x41;
  - `press_cnt`=1.
- Bytes E0, 75, E0, F0, 75:
  - `key_ext`=1, `key_code`=0x75, `key_ascii`=0x00;
  - `key_active` ends at 0.
- With `HIST_DEPTH`=4, `hist_pop`=0:
  - Send five distinct makes (with breaks): `hist_level`=4, `overflow`=1, head=first key.
  - Then pop 4 times: `hist_valid`=0.
- With `CNT_W`=8, send 256 distinct make/break pairs: `press_cnt` wraps 0xFF→0x00.
- Assert `rst` between E0 and 75, then send 75: `key_ext`=0, `key_code`=0x75, and the FIFO holds exactly 1 entry.
